// File: rtl/hdmi_line_scaler.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_line_scaler
// Purpose  : Ping-pong line-buffered integer upscaler with raster generation,
//            underrun detection and optional scanline dimming.
// Revision : 1.0
// ============================================================================
module hdmi_line_scaler #(
  parameter int IWIDTH        = 256,
  parameter int IHEIGHT       = 240,
  parameter int SCALE_X       = 2,
  parameter int SCALE_Y       = 2,
  parameter int OFRAME_WIDTH  = 858,
  parameter int OFRAME_HEIGHT = 525,
  parameter int X_OFFSET      = (720 - IWIDTH*SCALE_X)/2,
  parameter int Y_OFFSET      = 0,
  parameter int CW            = 8
) (
  input  logic            clk_h,
  input  logic            rst_h,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3*CW-1:0] in_rgb,
  input  logic            in_sol,
  input  logic [3*CW-1:0] border_rgb,
  input  logic            scanline_en,
  output logic            frame_start,
  output logic [9:0]      hx,
  output logic [9:0]      hy,
  output logic [3*CW-1:0] out_rgb,
  output logic            out_de,
  output logic            underrun
);

  localparam int PW  = 3*CW;
  localparam int AW  = (IWIDTH > 1) ? $clog2(IWIDTH) : 1;
  localparam int MW  = $clog2(2*IWIDTH);
  localparam int SXW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
  localparam int SYW = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;

  localparam logic [10:0]    c_X_BEG   = 11'(X_OFFSET);
  localparam logic [10:0]    c_X_SPAN  = 11'(IWIDTH*SCALE_X);
  localparam logic [10:0]    c_Y_BEG   = 11'(Y_OFFSET);
  localparam logic [10:0]    c_Y_SPAN  = 11'(IHEIGHT*SCALE_Y);
  localparam logic [9:0]     c_HX_LAST = 10'(OFRAME_WIDTH-1);
  localparam logic [9:0]     c_HY_LAST = 10'(OFRAME_HEIGHT-1);
  // X_OFFSET must be at least 1 so the line-start check column exists.
  localparam logic [9:0]     c_CHK_COL = 10'(X_OFFSET-1);
  localparam logic [AW-1:0]  c_WX_LAST = AW'(IWIDTH-1);
  localparam logic [SXW-1:0] c_SX_LAST = SXW'(SCALE_X-1);
  localparam logic [SYW-1:0] c_SY_LAST = SYW'(SCALE_Y-1);
  localparam logic [MW-1:0]  c_BANK1   = MW'(IWIDTH);
  localparam logic           c_DIM_OK  = (SCALE_Y > 1);

  logic [9:0]     r_hx;
  logic [9:0]     r_hy;
  logic [AW-1:0]  r_wx;
  logic [AW-1:0]  r_rx;
  logic           r_wb;
  logic           r_rb;
  logic [1:0]     r_full;
  logic [SXW-1:0] r_subx;
  logic [SYW-1:0] r_suby;
  logic           r_good;
  logic           r_under;
  logic [PW-1:0]  r_mem [0:2*IWIDTH-1];
  logic [PW-1:0]  r_rd_data;
  logic           r_s1_de;
  logic           r_s1_bad;
  logic           r_s1_dim;
  logic           r_out_de;
  logic [PW-1:0]  r_out_rgb;

  logic           w_accept;
  logic           w_wr_last;
  logic [AW-1:0]  w_waddr;
  logic [MW-1:0]  w_wr_idx;
  logic [MW-1:0]  w_rd_idx;
  logic           w_hx_last;
  logic           w_col_act;
  logic           w_row_act;
  logic           w_act;
  logic           w_chk;
  logic           w_release;
  logic [PW-1:0]  w_dim_rgb;

  assign in_ready  = ~r_full[r_wb];
  assign w_accept  = in_valid & in_ready;
  assign w_waddr   = in_sol ? '0 : r_wx;
  assign w_wr_last = (w_waddr == c_WX_LAST);
  assign w_wr_idx  = r_wb ? (c_BANK1 + MW'(w_waddr)) : MW'(w_waddr);
  assign w_rd_idx  = r_rb ? (c_BANK1 + MW'(r_rx)) : MW'(r_rx);

  // Window tests use a wrapped offset so one unsigned compare covers both bounds.
  assign w_hx_last = (r_hx == c_HX_LAST);
  assign w_col_act = (({1'b0, r_hx} - c_X_BEG) < c_X_SPAN);
  assign w_row_act = (({1'b0, r_hy} - c_Y_BEG) < c_Y_SPAN);
  assign w_act     = w_col_act & w_row_act;
  assign w_chk     = w_row_act && (r_suby == '0) && (r_hx == c_CHK_COL);
  assign w_release = w_row_act && w_hx_last && (r_suby == c_SY_LAST) && r_good;

  for (genvar c = 0; c < 3; c++) begin : g_dim
    assign w_dim_rgb[c*CW +: CW] = {1'b0, r_rd_data[c*CW+1 +: CW-1]};
  end

  always_ff @(posedge clk_h or posedge rst_h) begin
    if (rst_h) begin
      r_wx   <= '0;
      r_wb   <= 1'b0;
      r_rb   <= 1'b0;
      r_full <= 2'b00;
    end else begin
      if (w_accept) begin
        if (w_wr_last) begin
          r_full[r_wb] <= 1'b1;
          r_wb         <= ~r_wb;
          r_wx         <= '0;
        end else begin
          r_wx <= w_waddr + AW'(1);
        end
      end
      // A completing write and a release always touch different banks.
      if (w_release) begin
        r_full[r_rb] <= 1'b0;
        r_rb         <= ~r_rb;
      end
    end
  end

  always_ff @(posedge clk_h or posedge rst_h) begin
    if (rst_h) begin
      r_hx    <= '0;
      r_hy    <= '0;
      r_subx  <= '0;
      r_rx    <= '0;
      r_suby  <= '0;
      r_good  <= 1'b0;
      r_under <= 1'b0;
    end else begin
      if (w_hx_last) begin
        r_hx <= '0;
        r_hy <= (r_hy == c_HY_LAST) ? '0 : r_hy + 10'd1;
      end else begin
        r_hx <= r_hx + 10'd1;
      end

      if (w_col_act) begin
        if (r_subx == c_SX_LAST) begin
          r_subx <= '0;
          if (r_rx != c_WX_LAST) r_rx <= r_rx + AW'(1);
        end else begin
          r_subx <= r_subx + SXW'(1);
        end
      end else begin
        r_subx <= '0;
        r_rx   <= '0;
      end

      if (!w_row_act) begin
        r_suby <= '0;
      end else if (w_hx_last) begin
        r_suby <= (r_suby == c_SY_LAST) ? '0 : r_suby + SYW'(1);
      end

      if (w_chk) begin
        r_good <= r_full[r_rb];
        if (!r_full[r_rb]) r_under <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_h) begin
    if (w_accept) r_mem[w_wr_idx] <= in_rgb;
    r_rd_data <= r_mem[w_rd_idx];
  end

  always_ff @(posedge clk_h or posedge rst_h) begin
    if (rst_h) begin
      r_s1_de   <= 1'b0;
      r_s1_bad  <= 1'b0;
      r_s1_dim  <= 1'b0;
      r_out_de  <= 1'b0;
      r_out_rgb <= '0;
    end else begin
      r_s1_de  <= w_act;
      r_s1_bad <= w_act & ~r_good;
      r_s1_dim <= w_act & c_DIM_OK & scanline_en & (r_suby == c_SY_LAST);
      r_out_de <= r_s1_de;
      if (!r_s1_de || r_s1_bad) begin
        r_out_rgb <= border_rgb;
      end else if (r_s1_dim) begin
        r_out_rgb <= w_dim_rgb;
      end else begin
        r_out_rgb <= r_rd_data;
      end
    end
  end

  assign frame_start = (r_hx == '0) && (r_hy == '0);
  assign hx          = r_hx;
  assign hy          = r_hy;
  assign out_rgb     = r_out_rgb;
  assign out_de      = r_out_de;
  assign underrun    = r_under;

endmodule
`default_nettype wire

// File: doc/hdmi_line_scaler.md
# hdmi_line_scaler

Single-clock, parametrised integer upscaler for the HDMI output path. It accepts source pixels over a valid/ready stream and stores them in a ping-pong pair of line buffers. It generates the output raster counters and replays each source line SCALE_X times horizontally and SCALE_Y times vertically, centred on a border-coloured field. Compared with the earlier dual-clock scaler it adds:
- a backpressured input;
- arbitrary scale factors and colour depth;
- underrun detection;
- an optional scanline-dimming mode.

## Interface
Parameters:
- IWIDTH, 256, active source pixels per line
- IHEIGHT, 240, active source lines per frame
- SCALE_X, 2, horizontal replication factor (>=1)
- SCALE_Y, 2, vertical replication factor (>=1)
- OFRAME_WIDTH, 858, output clocks per line including blanking
- OFRAME_HEIGHT, 525, output lines per frame including blanking
- X_OFFSET, (720-IWIDTH*SCALE_X)/2, first active output column
- Y_OFFSET, 0, first active output row
- CW, 8, bits per colour channel; pixel width is 3*CW

Ports:
- clk_h  in  1  HDMI pixel clock
- rst_h  in  1  reset, asynchronous, active-high
- in_valid  in  1  source pixel valid
- in_ready  out  1  scaler can accept a pixel
- in_rgb  in  3*CW  source pixel {R,G,B}
- in_sol  in  1  qualifies the first pixel of a source line
- border_rgb  in  3*CW  colour outside the active window and on underrun lines
- scanline_en  in  1  enables dimming of the last sub-line of each group
- frame_start  out  1  one-cycle pulse when hx==0 && hy==0
- hx, hy  out  10  output raster counters
- out_rgb  out  3*CW  output pixel
- out_de  out  1  active-window flag, aligned with out_rgb
- underrun  out  1  sticky flag; cleared only by reset

## Operation
- **Buffers:** two line banks, each IWIDTH deep, with a full flag per bank and write pointer wb / read pointer rb.
- **Write side:**
  - in_ready = !full[wb].
  - Accept a pixel on in_valid && in_ready and write it to bank wb at address wx.
  - in_sol on an accepted pixel forces that pixel to address 0; wx then continues from 1.
  - When the pixel at address IWIDTH-1 is accepted: set full[wb], toggle wb, wx<=0.
- **Raster:**
  - hx counts 0..OFRAME_WIDTH-1 and wraps.
  - hy increments on hx wrap and counts 0..OFRAME_HEIGHT-1.
  - active = X_OFFSET<=hx<X_OFFSET+IWIDTH*SCALE_X and Y_OFFSET<=hy<Y_OFFSET+IHEIGHT*SCALE_Y.
- **Replication:**
  - sub_x counts 0..SCALE_X-1 within the active columns; the read address increments when sub_x wraps.
  - sub_y counts 0..SCALE_Y-1 across active rows.
- **Line start check:** sampled at hx==X_OFFSET-1 on each active row with sub_y==0.
  - If full[rb] is set: the line group is good.
  - If full[rb] is clear: underrun<=1, and the whole SCALE_Y-line group is marked bad and outputs border_rgb with out_de=1.
- **Bank release:** at hx==OFRAME_WIDTH-1 on the last sub-line (sub_y==SCALE_Y-1) of a good group, clear full[rb] and toggle rb. Bad groups release nothing.
- **Scanline dimming:** when scanline_en && SCALE_Y>1 && sub_y==SCALE_Y-1, each channel of a buffer pixel is output right-shifted by 1. Border pixels are never dimmed.
- **Simultaneous events:** a write completing into bank X and a release of bank Y in the same cycle both take effect. A completing write never targets a full bank, because in_ready blocks it.

## Timing
- Reset values:
  - hx=0, hy=0, wb=rb=0, both full flags 0, wx=0.
  - in_ready=1, underrun=0, out_de=0, out_rgb=0.
  - frame_start=1 during the first cycle after reset release, since hx=hy=0.
- Pipeline: out_rgb and out_de lag the hx/hy that produced them by exactly 2 clocks (registered buffer read, then output register).
- The input accepts up to one pixel per clock. in_ready falls the cycle after the completing write when the other bank is also full.
- Reset mid-line: everything returns to reset values immediately (asynchronous). Partially written lines are discarded.
- The counters must stay within 10 bits: OFRAME_WIDTH, OFRAME_HEIGHT <= 1024.

## Test plan
- **Steady state:** defaults, with the source always valid and a ramp on in_rgb (pixel n = n). Required response:
  - source pixel k appears on out_rgb for 2 consecutive cycles, repeated on 2 consecutive rows;
  - out_de is high for 512 cycles starting 2 clocks after hx==104;
  - underrun stays 0.
- **Backpressure:** fill both banks with no reads, before active rows start. Required response: in_ready=0 after the 512th accepted pixel, and it returns to 1 the cycle after the first bank release.
- **Underrun:** hold in_valid=0 through frame 1. Required response:
  - rows 0..479 show border_rgb with out_de=1;
  - underrun=1 from X_OFFSET of row 0 and stays set;
  - no bank is released.
- **Scanline mode:** scanline_en=1 with constant pixel 0xFF8040. Required response: even active rows output 0xFF8040 and odd active rows output 0x7F4020.
- **Resync:** assert in_sol mid-line at wx=100. Required response: that pixel is written to address 0, and the line completes 256 pixels later.
- **Async reset:** assert rst_h mid-active-line. Required response: out_de, hx, hy and underrun are 0 without waiting for a clock edge, and in_ready=1.
